// File: rtl/iobuf_dir_ctrl.sv
// ---------------------------------------------------------------------------
// iobuf_dir_ctrl
//
// Direction sequencer for one pin served by a 74LVC1T45 bidirectional buffer
// and a 74LVC1G07 open-drain buffer. Mode changes run break-before-make:
// release all drivers, wait, flip the buffer direction, wait, then engage
// the new driver. The FPGA side therefore never drives against the buffer.
//
// Ports:
//   clock      system clock
//   reset      asynchronous, active-high reset
//   mode_req   requested mode: 00 input, 01 push-pull, 10 open-drain,
//              11 treated as input
//   mode_valid request strobe, only sampled while busy is low
//   busy       a mode change sequence is in progress
//   mode_ack   one-cycle pulse when the requested mode is engaged
//   cur_mode   currently engaged mode
//   dout       data to drive (push-pull level, open-drain 0=low 1=release)
//   din        bufio_in after a SYNC_STAGES-deep synchroniser
//   bufdir     74LVC1T45 DIR, 0 = header towards FPGA
//   bufod      74LVC1G07 input, 1 = HiZ, 0 = pull low
//   bufio_oe   FPGA tristate enable for bufio
//   bufio_out  FPGA drive value for bufio
//   bufio_in   raw bufio pin value
// ---------------------------------------------------------------------------
module iobuf_dir_ctrl #(
    parameter int DEAD_CYCLES = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] mode_req,
    input  logic       mode_valid,
    output logic       busy,
    output logic       mode_ack,
    output logic [1:0] cur_mode,
    input  logic       dout,
    output logic       din,
    output logic       bufdir,
    output logic       bufod,
    output logic       bufio_oe,
    output logic       bufio_out,
    input  logic       bufio_in
);

    localparam int CNT_W = $clog2(DEAD_CYCLES + 1);
    // A wait state is entered with DEAD_CYCLES-1 loaded and leaves on the
    // edge where the count reads zero, giving exactly DEAD_CYCLES cycles.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_CYCLES - 1);

    localparam logic [1:0] MODE_IN = 2'b00;
    localparam logic [1:0] MODE_PP = 2'b01;
    localparam logic [1:0] MODE_OD = 2'b10;

    typedef enum logic [2:0] {
        ST_STABLE,
        ST_RELEASE,
        ST_WAIT_A,
        ST_SETDIR,
        ST_WAIT_B,
        ST_ENGAGE
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       target_reg;
    logic [1:0]       cur_mode_reg;
    logic             busy_reg;
    logic             mode_ack_reg;
    logic             bufdir_reg;
    logic             bufod_reg;
    logic             bufio_oe_reg;
    logic             bufio_out_reg;
    logic [1:0]       req_mode;
    logic [SYNC_STAGES-1:0] sync_reg;

    assign req_mode = (mode_req == 2'b11) ? MODE_IN : mode_req;

    // Registered outputs and sequencer. The state names describe what has
    // already been applied to the pins: RELEASE is entered with every driver
    // off, SETDIR with the new direction, ENGAGE with the new driver on.
    // ENGAGE is the first engaged cycle and accepts requests like STABLE so
    // that no request is lost while busy is already low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_STABLE;
            cnt_reg       <= '0;
            target_reg    <= MODE_IN;
            cur_mode_reg  <= MODE_IN;
            busy_reg      <= 1'b0;
            mode_ack_reg  <= 1'b0;
            bufdir_reg    <= 1'b0;
            bufod_reg     <= 1'b1;
            bufio_oe_reg  <= 1'b0;
            bufio_out_reg <= 1'b0;
        end else begin
            mode_ack_reg <= 1'b0;
            case (state_reg)
                ST_STABLE, ST_ENGAGE: begin
                    state_reg <= ST_STABLE;
                    if (mode_valid && (req_mode != cur_mode_reg)) begin
                        // Break first: both drivers released on this edge.
                        target_reg   <= req_mode;
                        bufio_oe_reg <= 1'b0;
                        bufod_reg    <= 1'b1;
                        busy_reg     <= 1'b1;
                        state_reg    <= ST_RELEASE;
                    end else begin
                        if (mode_valid) begin
                            mode_ack_reg <= 1'b1;
                        end
                        case (cur_mode_reg)
                            MODE_PP: bufio_out_reg <= dout;
                            MODE_OD: bufod_reg     <= dout;
                            default: ;
                        endcase
                    end
                end
                ST_RELEASE: begin
                    cnt_reg   <= CNT_LOAD;
                    state_reg <= ST_WAIT_A;
                end
                ST_WAIT_A: begin
                    if (cnt_reg == '0) begin
                        bufdir_reg <= (target_reg == MODE_PP);
                        state_reg  <= ST_SETDIR;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_SETDIR: begin
                    cnt_reg   <= CNT_LOAD;
                    state_reg <= ST_WAIT_B;
                end
                ST_WAIT_B: begin
                    if (cnt_reg == '0) begin
                        case (target_reg)
                            MODE_PP: begin
                                bufio_oe_reg  <= 1'b1;
                                bufio_out_reg <= dout;
                            end
                            MODE_OD: bufod_reg <= dout;
                            default: ;
                        endcase
                        cur_mode_reg <= target_reg;
                        mode_ack_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                        state_reg    <= ST_ENGAGE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= ST_STABLE;
            endcase
        end
    end

    // Input synchroniser: stage 0 samples the raw pin, each later stage
    // samples the one before it; din is the last stage.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    sync_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= bufio_in;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign din       = sync_reg[SYNC_STAGES-1];
    assign busy      = busy_reg;
    assign mode_ack  = mode_ack_reg;
    assign cur_mode  = cur_mode_reg;
    assign bufdir    = bufdir_reg;
    assign bufod     = bufod_reg;
    assign bufio_oe  = bufio_oe_reg;
    assign bufio_out = bufio_out_reg;

endmodule
